// File: rtl/seq_pipe_reg_dffre_param.sv
// -----------------------------------------------------------------------------
// seq_pipe_reg_dffre_param
//
// Purpose:
//   Stallable delay line of DEPTH stages, each stage holding WIDTH data bits
//   plus a valid bit. A global enable advances the whole pipe (lock-step mode).
//   With COLLAPSE=1, empty stages keep filling while the output is stalled,
//   so bubbles are squeezed out and the pipe pre-fills toward the output.
//   A synchronous flush and the synchronous active-low reset empty every stage
//   and load RESET_VALUE into all data registers.
//
// Parameters:
//   WIDTH       data bits per stage (>=1)
//   DEPTH       number of stages (>=1)
//   RESET_VALUE data value loaded into every stage on reset/flush
//   COLLAPSE    0 = lock-step shift on en, 1 = invalid stages absorb bubbles
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   reset    in   synchronous reset, active-low
//   en       in   advance / output-consume enable
//   clear    in   synchronous flush, active-high
//   in_val   in   valid bit accompanying d
//   d        in   input data
//   in_rdy   out  stage 0 loads this cycle (combinational)
//   out_val  out  valid bit of the last stage
//   q        out  data of the last stage
//   occ      out  number of valid stages
// -----------------------------------------------------------------------------
module seq_pipe_reg_dffre_param #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter bit               COLLAPSE    = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         clear,
    input  logic                         in_val,
    input  logic [WIDTH-1:0]             d,
    output logic                         in_rdy,
    output logic                         out_val,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // Number of set bits in a valid vector; sized so that DEPTH itself fits.
    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
        logic [OCC_W-1:0] cnt;
        cnt = {OCC_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + OCC_W'(vec[i]);
        end
        return cnt;
    endfunction

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [DEPTH-1:0] ld_s;

    // Per-stage load enables. In collapse mode a stage may load when it is
    // empty or when the stage after it is loading; the chain is built from the
    // output end backwards with a scalar carry to keep it a simple ripple.
    always_comb begin
        logic carry;
        ld_s  = {DEPTH{1'b0}};
        carry = 1'b0;
        if (COLLAPSE) begin
            carry           = en | ~v_q[DEPTH-1];
            ld_s[DEPTH-1]   = carry;
            for (int i = DEPTH - 2; i >= 0; i--) begin
                carry   = ~v_q[i] | carry;
                ld_s[i] = carry;
            end
        end else begin
            ld_s = {DEPTH{en}};
        end
    end

    // Next-state shift: a loading stage takes its predecessor (or the input
    // for stage 0); a non-loading stage holds. Data of invalid entries is
    // still moved so q stays deterministic.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (ld_s[0]) begin
            v_d[0]    = in_val;
            data_d[0] = d;
        end else begin
            v_d[0]    = v_q[0];
            data_d[0] = data_q[0];
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (ld_s[i]) begin
                v_d[i]    = v_q[i-1];
                data_d[i] = data_q[i-1];
            end else begin
                v_d[i]    = v_q[i];
                data_d[i] = data_q[i];
            end
        end
    end

    // Stage registers and occupancy; reset and flush both empty the pipe and
    // discard whatever is presented on the input that cycle.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            v_q   <= {DEPTH{1'b0}};
            occ_q <= {OCC_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= popcount(v_d);
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign in_rdy  = ld_s[0];
    assign out_val = v_q[DEPTH-1];
    assign q       = data_q[DEPTH-1];
    assign occ     = occ_q;

endmodule

// File: tb/tb_seq_pipe_reg_dffre_param.sv
// -----------------------------------------------------------------------------
// tb_seq_pipe_reg_dffre_param
//
// Directed bench for seq_pipe_reg_dffre_param. Four instances share one set of
// input drivers: lock-step (u0), collapse (u1), lock-step with a non-zero reset
// value (u2) and a single-stage variant (u3). Each phase checks the instance
// it targets; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_seq_pipe_reg_dffre_param;

    logic       clk;
    logic       reset;
    logic       en;
    logic       clear;
    logic       in_val;
    logic [7:0] d;

    logic       rdy0, ov0, rdy1, ov1, rdy2, ov2, rdy3, ov3;
    logic [7:0] q0, q1, q2, q3;
    logic [2:0] occ0, occ1, occ2;
    logic [0:0] occ3;

    int n_chk;
    int n_pass;

    seq_pipe_reg_dffre_param #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00), .COLLAPSE(1'b0)) u0 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .in_val(in_val), .d(d),
        .in_rdy(rdy0), .out_val(ov0), .q(q0), .occ(occ0));

    seq_pipe_reg_dffre_param #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00), .COLLAPSE(1'b1)) u1 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .in_val(in_val), .d(d),
        .in_rdy(rdy1), .out_val(ov1), .q(q1), .occ(occ1));

    seq_pipe_reg_dffre_param #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h5a), .COLLAPSE(1'b0)) u2 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .in_val(in_val), .d(d),
        .in_rdy(rdy2), .out_val(ov2), .q(q2), .occ(occ2));

    seq_pipe_reg_dffre_param #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00), .COLLAPSE(1'b0)) u3 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .in_val(in_val), .d(d),
        .in_rdy(rdy3), .out_val(ov3), .q(q3), .occ(occ3));

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge, and inputs
    // set afterwards are stable well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] vals [4];
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        clear  = 1'b0;
        en     = 1'b0;
        in_val = 1'b0;
        d      = 8'h00;

        // Reset state.
        tick();
        tick();
        chk("rst_q0",    32'(q0),   32'h00);
        chk("rst_ov0",   32'(ov0),  32'h0);
        chk("rst_occ0",  32'(occ0), 32'h0);
        chk("rst_q2",    32'(q2),   32'h5a);
        chk("rst_rdy0",  32'(rdy0), 32'h0);
        chk("rst_rdy1",  32'(rdy1), 32'h1);
        reset = 1'b1;

        // Lock-step streaming: ab reaches q on the 4th edge.
        vals[0] = 8'hab; vals[1] = 8'hcd; vals[2] = 8'hef; vals[3] = 8'h12;
        en = 1'b1;
        in_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = vals[i];
            #1;
            chk("s_rdy0", 32'(rdy0), 32'h1);
            tick();
            chk("s_occ0", 32'(occ0), 32'(i + 1));
            chk("s_ov0",  32'(ov0),  (i == 3) ? 32'h1 : 32'h0);
        end
        chk("s_q0", 32'(q0), 32'hab);

        // Stall: everything holds, nothing accepted.
        en = 1'b0;
        d  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_rdy0", 32'(rdy0), 32'h0);
            tick();
            chk("st_q0",   32'(q0),   32'hab);
            chk("st_occ0", 32'(occ0), 32'h4);
        end

        // Resume and drain in order.
        en = 1'b1;
        in_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dr_q0",   32'(q0),   32'(vals[i + 1]));
            chk("dr_occ0", 32'(occ0), 32'(3 - i));
        end
        tick();
        chk("dr_ov0",   32'(ov0),  32'h0);
        chk("dr_occ0e", 32'(occ0), 32'h0);

        // Flush with occ=3 and a concurrent valid input.
        in_val = 1'b1;
        d = 8'h11; tick();
        d = 8'h22; tick();
        d = 8'h33; tick();
        d = 8'h44; tick();
        in_val = 1'b0;
        tick();
        chk("cl_pre_occ", 32'(occ0), 32'h3);
        chk("cl_pre_q",   32'(q0),   32'h22);
        clear  = 1'b1;
        in_val = 1'b1;
        d      = 8'hff;
        tick();
        chk("cl_occ", 32'(occ0), 32'h0);
        chk("cl_ov",  32'(ov0),  32'h0);
        chk("cl_q",   32'(q0),   32'h00);
        clear  = 1'b0;
        in_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cl_noff", 32'(ov0), 32'h0);
        end

        // Collapse fill while stalled: four taken, fifth refused.
        en = 1'b0;
        in_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'(i + 1);
            #1;
            chk("cf_rdy1", 32'(rdy1), 32'h1);
            tick();
            chk("cf_occ1", 32'(occ1), 32'(i + 1));
            chk("cf_ov1",  32'(ov1),  (i == 3) ? 32'h1 : 32'h0);
        end
        chk("cf_q1", 32'(q1), 32'h01);
        d = 8'h05;
        #1;
        chk("cf_full_rdy1", 32'(rdy1), 32'h0);
        tick();
        chk("cf_full_occ1", 32'(occ1), 32'h4);
        chk("cf_full_q1",   32'(q1),   32'h01);
        en = 1'b1;
        in_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cd_q1",   32'(q1),   32'(i + 2));
            chk("cd_occ1", 32'(occ1), 32'(3 - i));
        end
        tick();
        chk("cd_ov1",  32'(ov1),  32'h0);
        chk("cd_occ1", 32'(occ1), 32'h0);

        // Bubble collapse: pattern 1,0,1 with output stalled.
        en = 1'b0;
        in_val = 1'b1; d = 8'ha1; tick();
        in_val = 1'b0; d = 8'h00; tick();
        in_val = 1'b1; d = 8'ha3; tick();
        in_val = 1'b0;
        tick();
        tick();
        chk("bb_occ1", 32'(occ1), 32'h2);
        chk("bb_q1",   32'(q1),   32'ha1);
        chk("bb_ov1",  32'(ov1),  32'h1);
        tick();
        chk("bb_hold_q1", 32'(q1), 32'ha1);
        en = 1'b1;
        tick();
        chk("bb_adj_q1",   32'(q1),   32'ha3);
        chk("bb_adj_occ1", 32'(occ1), 32'h1);
        tick();
        chk("bb_end_ov1",  32'(ov1),  32'h0);

        // Reset mid-stream with a non-zero reset value.
        in_val = 1'b1;
        d = 8'h77;
        for (int i = 0; i < 4; i++) tick();
        chk("rm_pre_q2",   32'(q2),   32'h77);
        chk("rm_pre_occ2", 32'(occ2), 32'h4);
        reset = 1'b0;
        d = 8'h88;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rm_q2",   32'(q2),   32'h5a);
            chk("rm_ov2",  32'(ov2),  32'h0);
            chk("rm_occ2", 32'(occ2), 32'h0);
        end
        reset = 1'b1;
        en = 1'b0;
        in_val = 1'b0;
        tick();
        chk("rm_post_occ2", 32'(occ2), 32'h0);
        chk("rm_post_q2",   32'(q2),   32'h5a);

        // Single-stage variant.
        en = 1'b1;
        in_val = 1'b1;
        d = 8'h3c;
        #1;
        chk("d1_rdy", 32'(rdy3), 32'h1);
        tick();
        chk("d1_q",   32'(q3),   32'h3c);
        chk("d1_ov",  32'(ov3),  32'h1);
        chk("d1_occ", 32'(occ3), 32'h1);
        en = 1'b0;
        d = 8'h4d;
        #1;
        chk("d1_st_rdy", 32'(rdy3), 32'h0);
        tick();
        chk("d1_st_q",   32'(q3),   32'h3c);
        en = 1'b1;
        in_val = 1'b0;
        d = 8'h5e;
        tick();
        chk("d1_bub_q",   32'(q3),   32'h5e);
        chk("d1_bub_ov",  32'(ov3),  32'h0);
        chk("d1_bub_occ", 32'(occ3), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
